jtopl_acc: RTL and testbench



---
 rtl/jtopl_acc_if.sv | 27 ++
 rtl/jtopl_acc.sv | 110 +++++++++++
 tb/tb_jtopl_acc.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/jtopl_acc_if.sv
// Operator-side handshake and sample-side outputs of the output accumulator.
// The master side feeds operator results; the slave side is the accumulator.
interface jtopl_acc_if #(
    parameter int OUTW = 16
);
    logic                   cenop;
    logic                   zero;
    logic signed [12:0]     op_result;
    logic                   op_out;
    logic                   con_IV;
    logic                   peak_clr;
    logic        [OUTW-1:0] snd;
    logic                   sample;
    logic                   clip;
    logic        [4:0]      slot;
    logic        [OUTW-2:0] peak;

    modport master (
        output cenop, zero, op_result, op_out, con_IV, peak_clr,
        input  snd, sample, clip, slot, peak
    );

    modport slave (
        input  cenop, zero, op_result, op_out, con_IV, peak_clr,
        output snd, sample, clip, slot, peak
    );
endinterface

// File: rtl/jtopl_acc.sv
// Frame accumulator: sums audible slot results and dumps a saturated sample on zero.
// Define JTOPL_ACC_PEAK_EN to build the peak-magnitude tracker.
module jtopl_acc #(
    parameter int ACCW = 18,
    parameter int OUTW = 16
) (
    input  logic        clk,
    input  logic        rst,
    jtopl_acc_if.slave  bus
);
    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'((1 << (OUTW-1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_LO = ~SAT_HI;

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] contrib;
    logic        [4:0]      slot_q, slot_d;
    logic        [OUTW-1:0] snd_q, snd_d;
    logic                   clip_q, clip_d;
    logic                   sample_q, sample_d;
    logic        [OUTW-1:0] sat_val;
    logic                   ovf_hi, ovf_lo;
    logic                   dump;

    assign dump = bus.cenop & bus.zero;

    always_comb begin
        // op_result is taken as-is; one's-complement negatives are left uncorrected
        contrib = '0;
        if (bus.op_out | bus.con_IV)
            contrib = {{(ACCW-13){bus.op_result[12]}}, bus.op_result};

        ovf_hi  = acc_q > SAT_HI;
        ovf_lo  = acc_q < SAT_LO;
        sat_val = acc_q[OUTW-1:0];
        if (ovf_hi)
            sat_val = SAT_HI[OUTW-1:0];
        else if (ovf_lo)
            sat_val = SAT_LO[OUTW-1:0];
    end

    always_comb begin
        acc_d    = acc_q;
        slot_d   = slot_q;
        snd_d    = snd_q;
        clip_d   = clip_q;
        sample_d = 1'b0;
        if (bus.cenop) begin
            if (bus.zero) begin
                // the slot-0 result already belongs to the new frame
                snd_d    = sat_val;
                clip_d   = ovf_hi | ovf_lo;
                sample_d = 1'b1;
                acc_d    = contrib;
                slot_d   = 5'd0;
            end else begin
                acc_d  = acc_q + contrib;
                slot_d = (slot_q == 5'd17) ? 5'd0 : 5'(slot_q + 5'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            slot_q   <= '0;
            snd_q    <= '0;
            clip_q   <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            slot_q   <= slot_d;
            snd_q    <= snd_d;
            clip_q   <= clip_d;
            sample_q <= sample_d;
        end
    end

    assign bus.snd    = snd_q;
    assign bus.clip   = clip_q;
    assign bus.sample = sample_q;
    assign bus.slot   = slot_q;

`ifdef JTOPL_ACC_PEAK_EN
    logic [OUTW-1:0] mag;
    logic [OUTW-2:0] mag_c;
    logic [OUTW-2:0] peak_q, peak_d;

    always_comb begin
        // negating the most negative value leaves the sign set, so clamp it
        mag    = sat_val[OUTW-1] ? OUTW'(-sat_val) : sat_val;
        mag_c  = mag[OUTW-1] ? '1 : mag[OUTW-2:0];
        peak_d = peak_q;
        if (bus.peak_clr)
            peak_d = '0;
        else if (dump && mag_c > peak_q)
            peak_d = mag_c;
    end

    always_ff @(posedge clk) begin
        if (rst)
            peak_q <= '0;
        else
            peak_q <= peak_d;
    end

    assign bus.peak = peak_q;
`else
    assign bus.peak = '0;
`endif
endmodule

// File: tb/tb_jtopl_acc.sv
// Self-checking bench for jtopl_acc: directed frames from the test plan, then
// randomized slots checked against an integer frame-sum reference model.
module tb_jtopl_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtopl_acc_if #(.OUTW(16)) bus ();
    jtopl_acc #(.ACCW(18), .OUTW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state, in plain integers
    int  m_sum    = 0;
    int  m_slot   = 0;
    int  m_snd    = 0;
    int  m_clip   = 0;
    int  m_sample = 0;
    int  m_peak   = 0;
    bit  pclr     = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".sample"}, int'(bus.sample), m_sample);
        chk({tag, ".slot"},   int'(bus.slot), m_slot);
        chk({tag, ".snd"},    int'($signed(bus.snd)), m_snd);
        chk({tag, ".clip"},   int'(bus.clip), m_clip);
        chk({tag, ".peak"},   int'(bus.peak), m_peak);
    endtask

    task automatic step(input bit cen, input bit z, input int val, input bit oo, input bit con);
        int contr, a18, mag;
        @(negedge clk);
        bus.cenop     = cen;
        bus.zero      = z;
        bus.op_result = 13'(val);
        bus.op_out    = oo;
        bus.con_IV    = con;
        bus.peak_clr  = pclr;
        @(posedge clk);
        #1;
        contr    = (oo || con) ? val : 0;
        m_sample = 0;
        if (cen) begin
            if (z) begin
                a18      = (m_sum <<< 14) >>> 14;
                m_clip   = (a18 > 32767 || a18 < -32768) ? 1 : 0;
                m_snd    = (a18 > 32767) ? 32767 : (a18 < -32768) ? -32768 : a18;
                m_sample = 1;
                m_sum    = contr;
                m_slot   = 0;
`ifdef JTOPL_ACC_PEAK_EN
                mag = (m_snd < 0) ? -m_snd : m_snd;
                if (mag > 32767) mag = 32767;
                if (!pclr && mag > m_peak) m_peak = mag;
`endif
            end else begin
                m_sum  = m_sum + contr;
                m_slot = (m_slot == 17) ? 0 : m_slot + 1;
            end
        end
`ifdef JTOPL_ACC_PEAK_EN
        if (pclr) m_peak = 0;
`endif
        chk_all("step");
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst           = 1'b1;
        bus.cenop     = 1'b1;
        bus.zero      = 1'b1;
        bus.op_result = 13'd100;
        bus.op_out    = 1'b1;
        bus.con_IV    = 1'b0;
        bus.peak_clr  = 1'b0;
        m_sum = 0; m_slot = 0; m_snd = 0; m_clip = 0; m_sample = 0; m_peak = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            chk_all("reset");
        end
        @(negedge clk);
        rst       = 1'b0;
        bus.cenop = 1'b0;
        bus.zero  = 1'b0;
    endtask

    // n slots; carriers on even slots unless allcar; optional zero on the first
    // slot, whose dumped sample is then checked against a fixed value
    task automatic frame(input string tag, input int n, input int cval, input int mval,
                         input bit con, input bit allcar, input bit zfirst,
                         input bit dochk, input int esnd, input int eclip);
        bit oo;
        for (int i = 0; i < n; i++) begin
            oo = allcar ? 1'b1 : (i % 2 == 0);
            step(1'b1, zfirst && i == 0, oo ? cval : mval, oo, con);
            if (i == 0 && dochk) begin
                chk({tag, ".snd"},    int'($signed(bus.snd)), esnd);
                chk({tag, ".clip"},   int'(bus.clip), eclip);
                chk({tag, ".sample"}, int'(bus.sample), 1);
            end
        end
    endtask

    initial begin
        bus.cenop = 1'b0; bus.zero = 1'b0; bus.op_result = '0;
        bus.op_out = 1'b0; bus.con_IV = 1'b0; bus.peak_clr = 1'b0;
        do_reset(2);

        frame("f100",  18, 100, 100, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        frame("d1800", 18, 10, 500, 1'b0, 1'b0, 1'b1, 1'b1, 1800, 0);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("sample_clears", int'(bus.sample), 0);
        frame("d90",    18, 10, 500, 1'b1, 1'b0, 1'b1, 1'b1, 90, 0);
        frame("d4590",  18, 4095, 4095, 1'b0, 1'b1, 1'b1, 1'b1, 4590, 0);
        frame("dmax",   18, -4096, -4096, 1'b0, 1'b1, 1'b1, 1'b1, 32767, 1);
        frame("dmin",   5, 7, 7, 1'b0, 1'b1, 1'b1, 1'b1, -32768, 1);
        frame("dearly", 20, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 35, 0);
        chk("wrap_slot", int'(bus.slot), 1);

        frame("d0", 10, 1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
        chk("pre_rst_slot", int'(bus.slot), 9);
        do_reset(2);
        frame("post", 4, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        frame("drst", 18, 1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 4, 0);

        pclr = 1'b1;
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        pclr = 1'b0;
        frame("p0", 1, 1000, 1000, 1'b0, 1'b1, 1'b1, 1'b1, 18, 0);
        frame("p1", 1, -3000, -3000, 1'b0, 1'b1, 1'b1, 1'b1, 1000, 0);
        frame("p2", 1, 200, 200, 1'b0, 1'b1, 1'b1, 1'b1, -3000, 0);
        frame("p3", 1, 50, 50, 1'b0, 1'b1, 1'b1, 1'b1, 200, 0);
`ifdef JTOPL_ACC_PEAK_EN
        chk("peak_3000", int'(bus.peak), 3000);
`else
        chk("peak_off", int'(bus.peak), 0);
`endif
        pclr = 1'b1;
        frame("p4", 1, 40, 40, 1'b0, 1'b1, 1'b1, 1'b1, 50, 0);
        pclr = 1'b0;
        chk("peak_clr", int'(bus.peak), 0);
        frame("p5", 1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 40, 0);
`ifdef JTOPL_ACC_PEAK_EN
        chk("peak_40", int'(bus.peak), 40);
`else
        chk("peak_off2", int'(bus.peak), 0);
`endif

        for (int k = 0; k < 800; k++) begin
            logic signed [12:0] r;
            bit cen, z;
            r    = 13'($urandom);
            cen  = ($urandom_range(0, 3) != 0);
            z    = cen && ((m_slot == 17) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 24) == 0));
            pclr = ($urandom_range(0, 15) == 0);
            step(cen, z, int'(r), 1'($urandom), 1'($urandom));
        end
        pclr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
